// File: rtl/cve2_pkg.sv
// Shared core types: ALU/MD operator encodings, M-extension configuration and
// the EX issue controller's state and request record.
package cve2_pkg;

  typedef enum logic [6:0] {
    ALU_ADD  = 7'd0,
    ALU_SUB  = 7'd1,
    ALU_XOR  = 7'd2,
    ALU_OR   = 7'd3,
    ALU_AND  = 7'd4,
    ALU_SRA  = 7'd5,
    ALU_SRL  = 7'd6,
    ALU_SLL  = 7'd7,
    ALU_LT   = 7'd8,
    ALU_LTU  = 7'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum logic [1:0] {
    EX_CTRL_IDLE = 2'd0,
    EX_CTRL_BUSY = 2'd1,
    EX_CTRL_DONE = 2'd2
  } ex_ctrl_state_e;

  typedef struct packed {
    logic        is_md;
    alu_op_e     alu_op;
    md_op_e      md_op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ex_req_t;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/cve2_ex_ctrl_watchdog.sv
// Busy-cycle counter for the EX issue controller: flags a runaway operation at
// the limit and produces the registered one-cycle error pulse.
module cve2_ex_ctrl_watchdog #(
  parameter int unsigned MaxCycles = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic ex_valid,
  input  logic flush,
  input  logic unsup,
  output logic expired,
  output logic error
);

  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q;
  logic            error_q;

  // A result arriving in the limit cycle still wins over the abort.
  assign expired = busy & ~ex_valid & ~flush & (cnt_q == CntW'(MaxCycles));
  assign error   = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= unsup | expired;
      if (start) begin
        cnt_q <= CntW'(1);
      end else if (busy) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cve2_ex_ctrl.sv
// Issue/sequencing controller in front of the ALU and mult/div units.
// Optional busy-cycle performance counter enabled by CVE2_EX_CTRL_PERF_EN.
module cve2_ex_ctrl import cve2_pkg::*; #(
  parameter rv32m_e      RV32M     = RV32MFast,
  parameter int unsigned MaxCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_md_i,
  input  alu_op_e     req_alu_op_i,
  input  md_op_e      req_md_op_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        flush_i,
  output alu_op_e     alu_operator_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  output logic        alu_instr_first_cycle_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output md_op_e      multdiv_operator_o,
  output logic [1:0]  multdiv_signed_mode_o,
  output logic [31:0] multdiv_operand_a_o,
  output logic [31:0] multdiv_operand_b_o,
  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        error_o,
  output logic [31:0] perf_busy_cnt_o
);

  ex_ctrl_state_e state_q;
  ex_req_t        req_q;
  ex_req_t        req_in;
  logic [31:0]    result_q;
  logic           first_q;
  logic           busy, accept, md_unsup, start, wd_expired, md_active, is_div;

  assign req_in = '{is_md: req_is_md_i, alu_op: req_alu_op_i, md_op: req_md_op_i,
                    signed_mode: req_signed_mode_i, op_a: req_op_a_i, op_b: req_op_b_i};

  assign busy        = (state_q == EX_CTRL_BUSY);
  assign req_ready_o = ~rst_i & ~flush_i &
                       ((state_q == EX_CTRL_IDLE) | ((state_q == EX_CTRL_DONE) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o;
  assign md_unsup    = accept & req_is_md_i & (RV32M == RV32MNone);
  assign start       = accept & ~md_unsup;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EX_CTRL_IDLE;
      req_q    <= '0;
      result_q <= '0;
      first_q  <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (accept) req_q <= req_in;
      if (flush_i) begin
        state_q <= EX_CTRL_IDLE;
      end else if (start) begin
        state_q <= EX_CTRL_BUSY;
        first_q <= 1'b1;
      end else begin
        case (state_q)
          EX_CTRL_BUSY: begin
            if (ex_valid_i) begin
              state_q  <= EX_CTRL_DONE;
              result_q <= result_ex_i;
            end else if (wd_expired) begin
              state_q <= EX_CTRL_IDLE;
            end
          end
          EX_CTRL_DONE: if (rsp_ready_i) state_q <= EX_CTRL_IDLE;
          EX_CTRL_IDLE: state_q <= EX_CTRL_IDLE;
          default:      state_q <= EX_CTRL_IDLE;
        endcase
      end
    end
  end

  cve2_ex_ctrl_watchdog #(
    .MaxCycles(MaxCycles)
  ) u_watchdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (start),
    .busy     (busy),
    .ex_valid (ex_valid_i),
    .flush    (flush_i),
    .unsup    (md_unsup),
    .expired  (wd_expired),
    .error    (error_o)
  );

  // Flush drops the enables in its own cycle so the multdiv FSMs return to idle.
  assign md_active = busy & req_q.is_md & ~flush_i;
  assign is_div    = md_is_div(req_q.md_op);
  assign mult_en_o  = md_active & ~is_div;
  assign mult_sel_o = md_active & ~is_div;
  assign div_en_o   = md_active & is_div;
  assign div_sel_o  = md_active & is_div;

  assign alu_operator_o          = req_q.alu_op;
  assign alu_operand_a_o         = req_q.op_a;
  assign alu_operand_b_o         = req_q.op_b;
  assign alu_instr_first_cycle_o = first_q;
  assign multdiv_operator_o      = req_q.md_op;
  assign multdiv_signed_mode_o   = req_q.signed_mode;
  assign multdiv_operand_a_o     = req_q.op_a;
  assign multdiv_operand_b_o     = req_q.op_b;

  assign rsp_valid_o  = (state_q == EX_CTRL_DONE);
  assign rsp_result_o = result_q;

`ifdef CVE2_EX_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_busy_cnt_o = perf_q;
`else
  assign perf_busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cve2_ex_ctrl.sv
// Self-checking bench for cve2_ex_ctrl: directed scenarios plus random ops
// scored against a transaction-level model of latency, enables and results.
module tb_cve2_ex_ctrl;
  import cve2_pkg::*;

  localparam int unsigned MaxCycles = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_is_md = 1'b0;
  alu_op_e     req_alu_op = ALU_ADD;
  md_op_e      req_md_op = MD_OP_MULL;
  logic [1:0]  req_sm = '0;
  logic [31:0] req_a = '0, req_b = '0, result_ex = '0;
  logic        flush = 1'b0, ex_valid = 1'b0, rsp_ready = 1'b0;
  logic        req_ready, first, mult_en, div_en, mult_sel, div_sel, rsp_valid, error;
  alu_op_e     alu_operator;
  md_op_e      md_operator;
  logic [1:0]  md_sm;
  logic [31:0] alu_a, alu_b, md_a, md_b, rsp_result, perf;

  int          n_cmp = 0, n_err = 0;
  int unsigned exp_busy = 0;
  alu_op_e     alu_ops [10] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
                                ALU_SRA, ALU_SRL, ALU_SLL, ALU_LT, ALU_LTU};

  always #5 clk = ~clk;

  cve2_ex_ctrl #(.RV32M(RV32MFast), .MaxCycles(MaxCycles)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_is_md_i             (req_is_md),
    .req_alu_op_i            (req_alu_op),
    .req_md_op_i             (req_md_op),
    .req_signed_mode_i       (req_sm),
    .req_op_a_i              (req_a),
    .req_op_b_i              (req_b),
    .flush_i                 (flush),
    .alu_operator_o          (alu_operator),
    .alu_operand_a_o         (alu_a),
    .alu_operand_b_o         (alu_b),
    .alu_instr_first_cycle_o (first),
    .mult_en_o               (mult_en),
    .div_en_o                (div_en),
    .mult_sel_o              (mult_sel),
    .div_sel_o               (div_sel),
    .multdiv_operator_o      (md_operator),
    .multdiv_signed_mode_o   (md_sm),
    .multdiv_operand_a_o     (md_a),
    .multdiv_operand_b_o     (md_b),
    .ex_valid_i              (ex_valid),
    .result_ex_i             (result_ex),
    .rsp_valid_o             (rsp_valid),
    .rsp_ready_i             (rsp_ready),
    .rsp_result_o            (rsp_result),
    .error_o                 (error),
    .perf_busy_cnt_o         (perf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What the execution stage would compute; the controller only forwards it.
  function automatic logic [31:0] ref_result(input bit is_md, input alu_op_e op,
                                             input md_op_e mop, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (is_md) begin
      case (mop)
        MD_OP_MULL: return p[31:0];
        MD_OP_MULH: return p[63:32];
        MD_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
        default:    return (b == 0) ? a : a % b;
      endcase
    end
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      ALU_SRL: return a >> b[4:0];
      ALU_SLL: return a << b[4:0];
      ALU_LT:  return {31'd0, $signed(a) < $signed(b)};
      default: return {31'd0, a < b};
    endcase
  endfunction

  task automatic drive_req(input bit is_md, input alu_op_e op, input md_op_e mop,
                           input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_is_md = is_md; req_alu_op = op; req_md_op = mop;
    req_sm = sm; req_a = a; req_b = b;
  endtask

  task automatic scramble_req();
    req_valid = 1'b0; req_is_md = 1'($urandom); req_alu_op = alu_ops[$urandom_range(0, 9)];
    req_md_op = md_op_e'($urandom_range(0, 3)); req_a = $urandom; req_b = $urandom;
  endtask

  // Called at posedge+1. lat = BUSY cycle in which ex_valid is returned; beyond
  // MaxCycles the op is expected to be aborted by the watchdog.
  task automatic run_op(input string tag, input bit is_md, input alu_op_e op,
                        input md_op_e mop, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int rsp_wait);
    logic [31:0] exp;
    int          n_busy, n_first, n_rdy, n_men, n_msel, n_den, n_dsel, cyc;
    bit          done, completes, want_div;
    exp       = ref_result(is_md, op, mop, a, b);
    completes = (lat >= 1) && (lat <= int'(MaxCycles));
    n_busy    = completes ? lat : int'(MaxCycles);
    want_div  = is_md && (mop == MD_OP_DIV || mop == MD_OP_REM);
    {n_first, n_rdy, n_men, n_msel, n_den, n_dsel, cyc} = '0;
    drive_req(is_md, op, mop, sm, a, b);
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 1);
    @(posedge clk); #1;
    scramble_req();
    done = 1'b0;
    while (!done) begin
      cyc++;
      ex_valid  = (cyc == lat);
      result_ex = (cyc == lat) ? exp : $urandom;
      @(negedge clk);
      if (cyc == 1) begin
        if (is_md) begin
          chk({tag, "_md_a"}, md_a, a);
          chk({tag, "_md_b"}, md_b, b);
          chk({tag, "_md_op"}, md_operator, mop);
          chk({tag, "_md_sm"}, md_sm, sm);
        end else begin
          chk({tag, "_alu_a"}, alu_a, a);
          chk({tag, "_alu_b"}, alu_b, b);
          chk({tag, "_alu_op"}, alu_operator, op);
        end
      end
      n_first += int'(first); n_rdy += int'(req_ready);
      n_men += int'(mult_en); n_msel += int'(mult_sel);
      n_den += int'(div_en); n_dsel += int'(div_sel);
      @(posedge clk); #1;
      done = (cyc == lat) || (cyc == int'(MaxCycles));
    end
    ex_valid  = 1'b0;
    exp_busy += n_busy;
    chk({tag, "_first_cycles"}, n_first, 1);
    chk({tag, "_ready_while_busy"}, n_rdy, 0);
    chk({tag, "_mult_en_cycles"}, n_men, (is_md && !want_div) ? n_busy : 0);
    chk({tag, "_mult_sel_cycles"}, n_msel, (is_md && !want_div) ? n_busy : 0);
    chk({tag, "_div_en_cycles"}, n_den, want_div ? n_busy : 0);
    chk({tag, "_div_sel_cycles"}, n_dsel, want_div ? n_busy : 0);
    @(negedge clk);
    if (completes) begin
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_result"}, rsp_result, exp);
      chk({tag, "_ready_in_done"}, req_ready, 0);
      chk({tag, "_no_error"}, error, 0);
      repeat (rsp_wait) @(posedge clk);
      #1; @(negedge clk);
      chk({tag, "_rsp_held_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_held_result"}, rsp_result, exp);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_rsp_dropped"}, rsp_valid, 0);
    end else begin
      chk({tag, "_wd_error"}, error, 1);
      chk({tag, "_wd_no_rsp"}, rsp_valid, 0);
      chk({tag, "_wd_ready"}, req_ready, 1);
      @(posedge clk); #1; @(negedge clk);
      chk({tag, "_wd_error_pulse"}, error, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n_mul;
    logic [31:0] a0, b0, a1, b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_enables", {mult_en, div_en, mult_sel, div_sel, first}, 0);
    chk("rst_perf", perf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add", 1'b0, ALU_ADD, MD_OP_MULL, 2'b00, 32'd5, 32'd7, 1, 1);
    run_op("div", 1'b1, ALU_ADD, MD_OP_DIV, 2'b00, 32'd100, 32'd7, 37, 3);
`ifdef CVE2_EX_CTRL_PERF_EN
    chk("perf_after_two", perf, 38);
`else
    chk("perf_after_two", perf, 0);
`endif

    // Back-to-back: response handshake and new accept in the same cycle
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    drive_req(1'b0, ALU_XOR, MD_OP_MULL, 2'b00, a0, b0);
    @(posedge clk); #1;
    scramble_req();
    ex_valid = 1'b1; result_ex = ref_result(1'b0, ALU_XOR, MD_OP_MULL, a0, b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp0_valid", rsp_valid, 1);
    chk("b2b_rsp0_result", rsp_result, a0 ^ b0);
    rsp_ready = 1'b1;
    drive_req(1'b0, ALU_SUB, MD_OP_MULL, 2'b00, a1, b1);
    #1;
    chk("b2b_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b0; scramble_req();
    @(negedge clk);
    chk("b2b_no_bubble_first", first, 1);
    chk("b2b_rsp_cleared", rsp_valid, 0);
    chk("b2b_new_a", alu_a, a1);
    chk("b2b_busy_ready", req_ready, 0);
    ex_valid = 1'b1; result_ex = a1 - b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp1_result", rsp_result, a1 - b1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_busy += 2;

    // Flush on BUSY cycle 5 of a MULH, racing ex_valid and a new request
    drive_req(1'b1, ALU_ADD, MD_OP_MULH, 2'b11, $urandom, $urandom);
    @(posedge clk); #1;
    scramble_req();
    n_mul = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_mul += int'(mult_en & mult_sel);
      @(posedge clk); #1;
    end
    chk("flush_mult_cycles", n_mul, 4);
    flush = 1'b1; ex_valid = 1'b1; result_ex = $urandom;
    drive_req(1'b0, ALU_ADD, MD_OP_MULL, 2'b00, $urandom, $urandom);
    #1;
    chk("flush_mult_en_comb", {mult_en, mult_sel, div_en, div_sel}, 0);
    chk("flush_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; scramble_req();
    @(negedge clk);
    chk("flush_no_rsp", rsp_valid, 0);
    chk("flush_no_error", error, 0);
    chk("flush_idle_ready", req_ready, 1);
    chk("flush_no_accept", first, 0);
    @(posedge clk); #1;
    exp_busy += 5;

    // Watchdog: REM whose result never comes back
    run_op("rem_wd", 1'b1, ALU_ADD, MD_OP_REM, 2'b01, 32'd99, 32'd4, 0, 0);

    // Random ops against the model
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom), alu_ops[$urandom_range(0, 9)],
             md_op_e'($urandom_range(0, 3)), 2'($urandom), $urandom, $urandom,
             $urandom_range(1, 45), $urandom_range(0, 3));
    end

`ifdef CVE2_EX_CTRL_PERF_EN
    chk("perf_total", perf, exp_busy);
`else
    chk("perf_total", perf, 0);
`endif

    // Reset mid-operation acts like a flush and loses everything
    drive_req(1'b1, ALU_ADD, MD_OP_MULL, 2'b00, $urandom, $urandom);
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_enables", {mult_en, mult_sel, first}, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_perf", perf, 0);
    chk("rst_mid_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cve2_ex_ctrl.md
Name: cve2_ex_ctrl

Overview:
- Issue/sequencing controller in front of the execution stage (ALU + MUL/DIV).
- Accepts one operation at a time from a valid/ready requester and latches its operands.
- Drives the ALU operator/operands, the mult/div dynamic enables and static selects, and the first-cycle flag. Waits for the stage's valid, then holds the result until the consumer takes it.
- Adds flush and a watchdog that aborts runaway multi-cycle operations.

Parameters:
- RV32M, cve2_pkg::RV32MFast, mult/div configuration; when RV32MNone, MD requests complete immediately with error_o.
- MaxCycles, 40, watchdog limit in EX-busy cycles; must be >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_is_md_i  in  1  1 = mult/div op, 0 = ALU op
- req_alu_op_i  in  alu_op_e  ALU operator
- req_md_op_i  in  md_op_e  MD_OP_MULL/MULH/DIV/REM
- req_signed_mode_i  in  2  mult/div signedness
- req_op_a_i, req_op_b_i  in  32 each  operands
- flush_i  in  1  abort in-flight op, drop held result
- alu_operator_o  out  alu_op_e  to EX
- alu_operand_a_o, alu_operand_b_o  out  32 each  to EX
- alu_instr_first_cycle_o  out  1  high in first BUSY cycle only
- mult_en_o, div_en_o  out  1 each  dynamic enables, BUSY only
- mult_sel_o, div_sel_o  out  1 each  static selects, BUSY only
- multdiv_operator_o  out  md_op_e
- multdiv_signed_mode_o  out  2
- multdiv_operand_a_o, multdiv_operand_b_o  out  32 each
- ex_valid_i  in  1  EX result valid
- result_ex_i  in  32  EX result
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer ready
- rsp_result_o  out  32  held result
- error_o  out  1  one-cycle pulse on watchdog abort or unsupported MD op
- perf_busy_cnt_o  out  32  see Optional Feature

Behaviour:
- FSM states IDLE, BUSY, DONE.
- Reset values: state IDLE, all outputs 0, latched registers 0.
- req_ready_o = !flush_i & (IDLE | (DONE & rsp_ready_i)). In DONE this allows a back-to-back accept in the same cycle as the response handshake.
- On accept:
  - latch op/operands;
  - go to BUSY, except an MD op with RV32M==RV32MNone, which goes to IDLE with error_o pulsed.
  - Operands are driven from the latched registers only, never combinationally from req_*.
- In BUSY:
  - ALU op: mult/div enables and selects are 0.
  - MD op: exactly one of the mult or div enable/select pairs is 1.
  - alu_instr_first_cycle_o = 1 only in the first BUSY cycle.
  - Cycle counter starts at 1 and increments each BUSY cycle.
- BUSY with ex_valid_i = 1 at an edge: capture result_ex_i into rsp_result_o and go to DONE.
  - Latency is 1 cycle for single-cycle ALU ops: accept at edge N, rsp_valid_o high after edge N+1.
- BUSY with counter == MaxCycles and no ex_valid_i: go to IDLE, pulse error_o, no response.
- DONE: rsp_valid_o = 1, rsp_result_o stable until the handshake. On rsp_ready_i, go to IDLE, or to BUSY if a new request is accepted in the same cycle.
- flush_i in any state: go to IDLE next edge, clear rsp_valid_o, no error. Enables and selects drop combinationally in the flush cycle so the multdiv FSMs reset.
- Flush has priority over ex_valid_i, watchdog, and request acceptance.
- Reset mid-operation behaves as flush; the held result is lost.

Optional Feature:
- Macro CVE2_EX_CTRL_PERF_EN.
- Defined: perf_busy_cnt_o counts total BUSY cycles since reset, saturating at 32'hFFFF_FFFF.
- Undefined: perf_busy_cnt_o tied to 0 and no counter flops.

Decomposition:
- cve2_pkg additions:
  - ex_ctrl_state_e {EX_CTRL_IDLE, EX_CTRL_BUSY, EX_CTRL_DONE};
  - packed struct ex_req_t {is_md, alu_op, md_op, signed_mode, op_a, op_b}.
- Existing alu_op_e, md_op_e, rv32m_e are reused.
- Natural sub-module: cve2_ex_ctrl_watchdog (busy cycle counter + limit compare + error pulse).

Test Plan:
- ALU_ADD, a=5, b=7, ex_valid_i returned in the first BUSY cycle -> first_cycle=1 one cycle; rsp_valid_o after 1 cycle with result 12; req_ready_o=0 while BUSY.
- MD_OP_DIV, a=100, b=7, bench asserts ex_valid_i after 37 cycles with result 14 -> div_en_o/div_sel_o high exactly 37 cycles, mult_* 0, rsp_result_o=14 held until rsp_ready_i.
- rsp_ready_i=1 in DONE with a new request valid the same cycle -> both handshakes occur, state BUSY next cycle, no idle bubble.
- flush_i on BUSY cycle 5 of a MULH -> enables 0 combinationally, IDLE next edge, no rsp_valid_o, error_o=0.
- MD_OP_REM, ex_valid_i never asserted, MaxCycles=40 -> error_o pulses once after BUSY cycle 40, state IDLE, req_ready_o=1.
- With CVE2_EX_CTRL_PERF_EN defined: ops of 1 and 37 busy cycles -> perf_busy_cnt_o=38; undefined -> perf_busy_cnt_o=0.
